// File: rtl/cpu_arb_pkg.sv
// Shared definitions for the CPU memory-port arbiter: FSM states,
// requester identifiers and the default starvation limit.
package cpu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_F = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive data grants made while fetch is waiting and flags
// when fetch must be given the next arbitration.
module arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic f_req_i,
    input  logic data_win_i,
    input  logic fetch_win_i,
    output logic starve_o
);

    localparam logic [3:0] LIMIT_C = 4'(LIMIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Clear when fetch stops waiting or is served; count data wins otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if (!f_req_i || fetch_win_i) begin
            cnt_d = '0;
        end else if (data_win_i && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starve_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / load-store) arbiter for a single memory port.
// Data has priority; optional fetch starvation guard enabled by the
// macro ARB_STARVE_GUARD_EN.
module mem_port_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_ready,
    output logic              arb_busy
);

    arb_state_e        state_q, state_d;
    logic              arb_en, complete, win_f, win_d, starve_hit;
    req_id_e           winner;

    logic              f_gnt_q, d_gnt_q, f_rvalid_q, d_rvalid_q, mem_we_q;
    logic [DATA_W-1:0] f_rdata_q, d_rdata_q, mem_wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst_ni     (reset),
        .f_req_i    (f_req),
        .data_win_i (win_d),
        .fetch_win_i(win_f),
        .starve_o   (starve_hit)
    );
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign starve_hit          = 1'b0;
`endif

    // Next state: arbitrate when idle or on the completing BUSY cycle.
    always_comb begin
        state_d  = state_q;
        arb_en   = 1'b0;
        complete = 1'b0;
        win_f    = 1'b0;
        win_d    = 1'b0;
        winner   = (d_req && !(f_req && starve_hit)) ? REQ_D : REQ_F;
        case (state_q)
            IDLE:           arb_en = 1'b1;
            BUSY_F, BUSY_D: begin
                complete = mem_ready;
                arb_en   = mem_ready;
            end
            default:        arb_en = 1'b1;
        endcase
        if (arb_en) begin
            if (f_req || d_req) begin
                win_d   = (winner == REQ_D);
                win_f   = (winner == REQ_F);
                state_d = (winner == REQ_D) ? BUSY_D : BUSY_F;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant/completion pulses, captured read data and memory port drive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_gnt_q     <= 1'b0;
            d_gnt_q     <= 1'b0;
            f_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            f_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            f_gnt_q    <= win_f;
            d_gnt_q    <= win_d;
            f_rvalid_q <= complete && (state_q == BUSY_F);
            d_rvalid_q <= complete && (state_q == BUSY_D);
            if (complete && (state_q == BUSY_F)) begin
                f_rdata_q <= mem_read_data;
            end
            if (complete && (state_q == BUSY_D)) begin
                d_rdata_q <= mem_we_q ? '0 : mem_read_data;
            end
            if (win_f) begin
                mem_addr_q  <= f_addr;
                mem_we_q    <= 1'b0;
                mem_wdata_q <= '0;
            end else if (win_d) begin
                mem_addr_q  <= d_addr;
                mem_we_q    <= d_we;
                mem_wdata_q <= d_wdata;
            end else if (complete) begin
                mem_we_q    <= 1'b0;
            end
        end
    end

    assign f_gnt          = f_gnt_q;
    assign d_gnt          = d_gnt_q;
    assign f_rvalid       = f_rvalid_q;
    assign d_rvalid       = d_rvalid_q;
    assign f_rdata        = f_rdata_q;
    assign d_rdata        = d_rdata_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_en   = mem_we_q;
    assign mem_write_data = mem_wdata_q;
    assign arb_busy       = (state_q != IDLE);

endmodule
